// File: rtl/dcache_lsu.sv
// Byte-addressed data memory with a load/store front end: size modes, sign/zero
// extension, alignment checking, one-cycle registered response and a clearing sweep after reset.
module dcache_lsu #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   req_valid,
   output logic                                   req_ready,
   input  logic                                   req_write,
   input  logic [1:0]                             req_size,
   input  logic                                   req_unsigned,
   input  logic [ADDR_W-1:0]                      req_addr,
   input  logic [WIDTH-1:0]                       req_wdata,
   output logic                                   resp_valid,
   output logic [WIDTH-1:0]                       resp_rdata,
   output logic                                   resp_err,
   input  logic [ADDR_W-$clog2(WIDTH/8)-1:0]      dbg_addr,
   output logic [WIDTH-1:0]                       dbg_data
);

   localparam int NB     = WIDTH / 8;
   localparam int LNB    = $clog2(NB);
   localparam int NWORDS = DEPTH / NB;
   localparam int IDX_W  = ADDR_W - LNB;

   typedef enum logic {S_INIT, S_RUN} state_e;

   state_e              state_q;
   logic [IDX_W-1:0]    init_idx_q;
   logic                ready_q;
   logic                resp_valid_q;
   logic                resp_err_q;
   logic [WIDTH-1:0]    resp_rdata_q;

   logic [7:0]          mem_q [DEPTH];
   logic [7:0]          mem_d [DEPTH];

   logic                accept;
   logic [3:0]          nbytes;
   logic                size_err;
   logic                addr_err;
   logic                req_err;
   logic [WIDTH-1:0]    load_data;
   logic                load_sign;
   logic                resp_err_d;
   logic [WIDTH-1:0]    resp_rdata_d;

   // Handshake: a request transfers on any rising edge where req_valid && req_ready;
   // req_ready depends only on internal state, and the response appears for exactly
   // the following cycle with no back-pressure.
   assign accept   = req_valid && ready_q;
   assign nbytes   = 4'd1 << req_size;
   assign size_err = 32'(req_size) > 32'(LNB);
   assign addr_err = (req_addr & (ADDR_W'(nbytes) - ADDR_W'(1))) != '0;
   assign req_err  = size_err || addr_err;

   // Bytes above the access size take the sign of byte n-1, which the ascending loop has already seen.
   always_comb begin
      load_data = '0;
      load_sign = 1'b0;
      for (int i = 0; i < NB; i++) begin
         if (i < int'(nbytes)) begin
            load_data[8*i +: 8] = mem_q[req_addr + ADDR_W'(i)];
            if (i == int'(nbytes) - 1) begin
               load_sign = mem_q[req_addr + ADDR_W'(i)][7];
            end
         end else begin
            load_data[8*i +: 8] = {8{load_sign && !req_unsigned}};
         end
      end
   end

   assign resp_err_d   = accept && req_err;
   assign resp_rdata_d = (accept && !req_write && !req_err) ? load_data : '0;

   always_comb begin
      mem_d = mem_q;
      if (state_q == S_INIT) begin
         for (int w = 0; w < NB; w++) begin
            mem_d[{init_idx_q, LNB'(w)}] = 8'h00;
         end
      end else if (accept && req_write && !req_err) begin
         for (int i = 0; i < NB; i++) begin
            if (i < int'(nbytes)) begin
               mem_d[req_addr + ADDR_W'(i)] = req_wdata[8*i +: 8];
            end
         end
      end
   end

   // The array has no reset: a reset edge leaves it untouched and the INIT sweep clears it.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         mem_q <= mem_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_INIT;
         init_idx_q   <= '0;
         ready_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         case (state_q)
            S_INIT: begin
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               resp_rdata_q <= '0;
               init_idx_q   <= init_idx_q + IDX_W'(1);
               if (init_idx_q == IDX_W'(NWORDS - 1)) begin
                  state_q <= S_RUN;
                  ready_q <= 1'b1;
               end
            end
            S_RUN: begin
               resp_valid_q <= accept;
               resp_err_q   <= resp_err_d;
               resp_rdata_q <= resp_rdata_d;
            end
         endcase
      end
   end

   always_comb begin
      dbg_data = '0;
      for (int i = 0; i < NB; i++) begin
         dbg_data[8*i +: 8] = mem_q[{dbg_addr, LNB'(i)}];
      end
   end

   assign req_ready  = ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule
